// File: rtl/ps2_scancode_decoder_pkg.sv
// ps2_scancode_decoder_pkg: shared scancode constants, FSM states and event layout for the PS/2 decoder.
package ps2_pkg;
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E1 = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL = 8'h14;
    localparam logic [7:0] SC_ALT = 8'h11;
    localparam logic [7:0] SC_CAPS = 8'h58;
    localparam logic [7:0] DISCARD_LIST [6] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    localparam int FIFO_DEPTH = 4;
    localparam logic [2:0] PAUSE_LAST = 3'd6;
    typedef enum logic [2:0] {S_BASE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;
    typedef struct packed {
        logic ext;
        logic brk;
        logic [7:0] code;
    } ev_t;
    function automatic logic is_discard(input logic [7:0] b);
        for (int i = 0; i < 6; i++)
            if (b == DISCARD_LIST[i]) return 1'b1;
        return 1'b0;
    endfunction
endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if: byte input, event FIFO head/pop and status bundle; master = front end/consumer, slave = decoder.
interface ps2_scancode_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic       ev_pop;
    logic       ev_valid;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       overflow;
    logic       rx_err_flag;
    logic       shift;
    logic       ctrl;
    logic       alt;
    logic       caps_lock;
    modport master (
        output rx_data, rx_valid, rx_error, ev_pop,
        input  ev_valid, ev_code, ev_ext, ev_break, overflow, rx_err_flag, shift, ctrl, alt, caps_lock
    );
    modport slave (
        input  rx_data, rx_valid, rx_error, ev_pop,
        output ev_valid, ev_code, ev_ext, ev_break, overflow, rx_err_flag, shift, ctrl, alt, caps_lock
    );
endinterface

// File: rtl/ps2_scancode_decoder_fifo.sv
// event_fifo: synchronous FIFO; ports push_i/din_i, pop_i/dout_o, full_o, empty_o, count_o; clk, async active-high rst.
module event_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic do_push, do_pop;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    // a pop on empty is ignored; a push on full only lands if a pop frees a slot in the same cycle
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q] <= din_i;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            if (do_pop) rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: PS/2 set-2 prefix decoder with event FIFO and modifier tracking; clk, async active-high rst, dec_if (slave).
module ps2_scancode_decoder
    import ps2_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    ps2_scancode_decoder_if.slave dec_if
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic rx_valid_q, accept, push, is_pause;
    logic overflow_q, err_q, lshift_q, rshift_q, lctrl_q, rctrl_q, lalt_q, ralt_q, caps_q, caps_held_q;
    logic [7:0] b;
    ev_t ev, head;
    logic fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    assign b = dec_if.rx_data;
    // rising edge of the valid level: one acceptance per byte however long it is held
    assign accept = dec_if.rx_valid && !rx_valid_q;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        push     = 1'b0;
        is_pause = 1'b0;
        ev       = '{ext: 1'b0, brk: 1'b0, code: b};
        if (accept) begin
            if (dec_if.rx_error) begin
                state_d = S_BASE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    S_BASE: begin
                        if (b == SC_E0) state_d = S_EXT;
                        else if (b == SC_F0) state_d = S_BRK;
                        else if (b == SC_E1) begin
                            state_d = S_PAUSE;
                            cnt_d   = '0;
                        end else push = !is_discard(b);
                    end
                    S_EXT: begin
                        if (b == SC_F0) state_d = S_EXT_BRK;
                        else begin
                            ev.ext  = 1'b1;
                            push    = 1'b1;
                            state_d = S_BASE;
                        end
                    end
                    S_BRK: begin
                        ev.brk  = 1'b1;
                        push    = 1'b1;
                        state_d = S_BASE;
                    end
                    S_EXT_BRK: begin
                        ev.ext  = 1'b1;
                        ev.brk  = 1'b1;
                        push    = 1'b1;
                        state_d = S_BASE;
                    end
                    S_PAUSE: begin
                        // the pause sequence carries 7 bytes after E1; report it once as a bare E1
                        if (cnt_q == PAUSE_LAST) begin
                            ev.code  = SC_E1;
                            is_pause = 1'b1;
                            push     = 1'b1;
                            state_d  = S_BASE;
                            cnt_d    = '0;
                        end else cnt_d = cnt_q + 3'd1;
                    end
                    default: state_d = S_BASE;
                endcase
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_BASE;
            cnt_q       <= '0;
            rx_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            err_q       <= 1'b0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            lctrl_q     <= 1'b0;
            rctrl_q     <= 1'b0;
            lalt_q      <= 1'b0;
            ralt_q      <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_valid_q <= dec_if.rx_valid;
            if (accept && dec_if.rx_error) err_q <= 1'b1;
            if (push && fifo_full && !dec_if.ev_pop) overflow_q <= 1'b1;
            // modifiers follow every decoded event, including ones the full FIFO drops
            if (push && !is_pause) begin
                if (!ev.ext && ev.code == SC_LSHIFT) lshift_q <= !ev.brk;
                if (!ev.ext && ev.code == SC_RSHIFT) rshift_q <= !ev.brk;
                if (!ev.ext && ev.code == SC_CTRL) lctrl_q <= !ev.brk;
                if (ev.ext && ev.code == SC_CTRL) rctrl_q <= !ev.brk;
                if (!ev.ext && ev.code == SC_ALT) lalt_q <= !ev.brk;
                if (ev.ext && ev.code == SC_ALT) ralt_q <= !ev.brk;
                // caps_held suppresses toggling on typematic repeats of the make code
                if (!ev.ext && ev.code == SC_CAPS) begin
                    if (ev.brk) caps_held_q <= 1'b0;
                    else if (!caps_held_q) begin
                        caps_q      <= !caps_q;
                        caps_held_q <= 1'b1;
                    end
                end
            end
        end
    end
    event_fifo #(.WIDTH($bits(ev_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (ev),
        .pop_i   (dec_if.ev_pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );
    assign dec_if.ev_valid    = fifo_count != '0;
    assign dec_if.ev_code     = fifo_empty ? 8'h00 : head.code;
    assign dec_if.ev_ext      = !fifo_empty && head.ext;
    assign dec_if.ev_break    = !fifo_empty && head.brk;
    assign dec_if.overflow    = overflow_q;
    assign dec_if.rx_err_flag = err_q;
    assign dec_if.shift       = lshift_q || rshift_q;
    assign dec_if.ctrl        = lctrl_q || rctrl_q;
    assign dec_if.alt         = lalt_q || ralt_q;
    assign dec_if.caps_lock   = caps_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed self-checking bench for ps2_scancode_decoder.
module tb_ps2_scancode_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int passed = 0;
    always #5 clk = ~clk;
    ps2_scancode_decoder_if bus ();
    ps2_scancode_decoder dut (.clk(clk), .rst(rst), .dec_if(bus));
    // head = {ev_valid, ev_ext, ev_break, ev_code}; flags = {overflow, rx_err_flag, shift, ctrl, alt, caps_lock}
    wire [10:0] head  = {bus.ev_valid, bus.ev_ext, bus.ev_break, bus.ev_code};
    wire [5:0]  flags = {bus.overflow, bus.rx_err_flag, bus.shift, bus.ctrl, bus.alt, bus.caps_lock};

    task automatic send(input logic [7:0] b, input logic err = 1'b0, input int hold = 1);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        bus.rx_error = err;
        repeat (hold) @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        bus.ev_pop = 1'b1;
        @(negedge clk);
        bus.ev_pop = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        bus.ev_pop = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (head !== 11'h000) $display("FAIL reset_head: got %h exp %h", head, 11'h000); else passed++;
        checks++;
        if (flags !== 6'b0) $display("FAIL reset_flags: got %b exp %b", flags, 6'b0); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] disc [6] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
        do_reset();
        @(negedge clk);
        bus.rx_data = 8'h1C;
        bus.rx_valid = 1'b1;
        checks++;
        if (head !== 11'h000) $display("FAIL lat_pre: got %h exp %h", head, 11'h000); else passed++;
        @(negedge clk);
        checks++;
        if (head !== 11'h41C) $display("FAIL lat_post: got %h exp %h", head, 11'h41C); else passed++;
        bus.rx_valid = 1'b0;
        send(8'hF0);
        send(8'h1C);
        checks++;
        if (head !== 11'h41C) $display("FAIL make_head: got %h exp %h", head, 11'h41C); else passed++;
        pop();
        checks++;
        if (head !== 11'h51C) $display("FAIL break_head: got %h exp %h", head, 11'h51C); else passed++;
        pop();
        checks++;
        if (head !== 11'h000) $display("FAIL basic_empty: got %h exp %h", head, 11'h000); else passed++;
        for (int i = 0; i < 6; i++) send(disc[i]);
        checks++;
        if (head !== 11'h000) $display("FAIL discard: got %h exp %h", head, 11'h000); else passed++;
    endtask

    task automatic test_ext();
        do_reset();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        checks++;
        if (head !== 11'h675) $display("FAIL ext_make: got %h exp %h", head, 11'h675); else passed++;
        checks++;
        if (flags !== 6'b0) $display("FAIL ext_flags: got %b exp %b", flags, 6'b0); else passed++;
        pop();
        checks++;
        if (head !== 11'h775) $display("FAIL ext_break: got %h exp %h", head, 11'h775); else passed++;
    endtask

    task automatic test_modifiers();
        logic [7:0] seq [13] = '{8'h12, 8'h58, 8'h58, 8'hF0, 8'h58, 8'h58, 8'hF0, 8'h12, 8'h59, 8'hE0, 8'h14, 8'h11, 8'h14};
        logic [5:0] exp_f [13] = '{6'b001000, 6'b001001, 6'b001001, 6'b001001, 6'b001001, 6'b001000, 6'b001000, 6'b000000,
                                   6'b001000, 6'b001000, 6'b001100, 6'b001110, 6'b001110};
        logic [13:0] do_chk = 14'b1_1110_1101_1111;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            send(seq[i]);
            if (do_chk[i]) begin
                checks++;
                if (flags !== exp_f[i]) $display("FAIL mods_%0d: got %b exp %b", i, flags, exp_f[i]); else passed++;
                pop();
            end
        end
        send(8'hE0); send(8'hF0); send(8'h14);
        checks++;
        if (flags !== 6'b001110) $display("FAIL rctrl_rel: got %b exp %b", flags, 6'b001110); else passed++;
        pop();
        send(8'hF0); send(8'h14); pop();
        send(8'hF0); send(8'h11); pop();
        send(8'hF0); send(8'h59);
        checks++;
        if (flags !== 6'b000000) $display("FAIL mods_clear: got %b exp %b", flags, 6'b000000); else passed++;
    endtask

    task automatic test_overflow();
        logic [7:0] order [4] = '{8'h16, 8'h1E, 8'h26, 8'h36};
        do_reset();
        send(8'h15); send(8'h16); send(8'h1E); send(8'h26);
        checks++;
        if (flags !== 6'b0) $display("FAIL full_no_ovf: got %b exp %b", flags, 6'b0); else passed++;
        send(8'h25); send(8'h2E);
        checks++;
        if (flags !== 6'b100000) $display("FAIL ovf_set: got %b exp %b", flags, 6'b100000); else passed++;
        @(negedge clk);
        bus.rx_data = 8'h36; bus.rx_valid = 1'b1; bus.ev_pop = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0; bus.ev_pop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (head !== {3'b100, order[i]}) $display("FAIL order_%0d: got %h exp %h", i, head, {3'b100, order[i]}); else passed++;
            pop();
        end
        checks++;
        if (head !== 11'h000) $display("FAIL ovf_drain: got %h exp %h", head, 11'h000); else passed++;
        do_reset();
        @(negedge clk);
        bus.rx_data = 8'h1C; bus.rx_valid = 1'b1; bus.ev_pop = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0; bus.ev_pop = 1'b0;
        checks++;
        if (head !== 11'h41C) $display("FAIL empty_pushpop: got %h exp %h", head, 11'h41C); else passed++;
    endtask

    task automatic test_pause();
        do_reset();
        send(8'hE1); send(8'h14, 1'b0, 3); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0);
        checks++;
        if (head !== 11'h000) $display("FAIL pause_mid: got %h exp %h", head, 11'h000); else passed++;
        send(8'h77);
        checks++;
        if (head !== 11'h4E1) $display("FAIL pause_ev: got %h exp %h", head, 11'h4E1); else passed++;
        checks++;
        if (flags !== 6'b0) $display("FAIL pause_flags: got %b exp %b", flags, 6'b0); else passed++;
        pop();
        checks++;
        if (head !== 11'h000) $display("FAIL pause_single: got %h exp %h", head, 11'h000); else passed++;
        send(8'h1C, 1'b0, 3);
        pop();
        checks++;
        if (head !== 11'h000) $display("FAIL hold3: got %h exp %h", head, 11'h000); else passed++;
    endtask

    task automatic test_error();
        do_reset();
        send(8'hE0); send(8'h75, 1'b1);
        checks++;
        if (flags !== 6'b010000) $display("FAIL err_flag: got %b exp %b", flags, 6'b010000); else passed++;
        checks++;
        if (head !== 11'h000) $display("FAIL err_drop: got %h exp %h", head, 11'h000); else passed++;
        send(8'h1C);
        checks++;
        if (head !== 11'h41C) $display("FAIL err_resync: got %h exp %h", head, 11'h41C); else passed++;
        send(8'hE0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({head, flags} !== 17'h0) $display("FAIL async_rst: got %h exp %h", {head, flags}, 17'h0); else passed++;
        @(negedge clk);
        rst = 1'b0;
        send(8'h75);
        checks++;
        if (head !== 11'h475) $display("FAIL rst_after_e0: got %h exp %h", head, 11'h475); else passed++;
        pop();
        send(8'hE1); send(8'h14);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        send(8'h1C);
        checks++;
        if (head !== 11'h41C) $display("FAIL rst_in_pause: got %h exp %h", head, 11'h41C); else passed++;
    endtask

    initial begin
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        bus.ev_pop = 1'b0;
        test_reset();
        test_basic();
        test_ext();
        test_modifiers();
        test_overflow();
        test_pause();
        test_error();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
